// File: rtl/wadj_csr_cfg_master.sv
// AVMM initiator that programs the width-adjuster CSRs (threshold, then control),
// reads both back, retries the whole sequence on mismatch and times out on a lost response.
module wadj_csr_cfg_master #(
   parameter int unsigned           ADDR_WIDTH     = 8,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int unsigned           MAX_RETRY      = 2,
   parameter int unsigned           TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_start,
   input  logic                    cfg_rx_pause_en,
   input  logic [15:0]             cfg_rx_pause_threshold,
   input  logic [15:0]             cfg_drop_threshold,
   output logic                    cfg_busy,
   output logic                    cfg_done,
   output logic                    cfg_error,
   output logic [1:0]              cfg_err_code,
   output logic [ADDR_WIDTH-1:0]   avmm_address,
   output logic                    avmm_read,
   output logic                    avmm_write,
   output logic [DATA_WIDTH-1:0]   avmm_writedata,
   output logic [DATA_WIDTH/8-1:0] avmm_byteenable,
   input  logic [DATA_WIDTH-1:0]   avmm_readdata,
   input  logic                    avmm_readdata_valid
);

   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR    = BASE_ADDR;
   localparam logic [ADDR_WIDTH-1:0] THR_ADDR     = BASE_ADDR + ADDR_WIDTH'(4);
   localparam logic [RW-1:0]         RETRY_MAX    = RW'(MAX_RETRY);
   localparam logic [TW-1:0]         TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]            ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0]            ERR_MISMATCH = 2'b10;

   typedef enum logic [3:0] {
      IDLE,
      WR_THR,
      WR_CTRL,
      RD_THR,
      WAIT_THR,
      RD_CTRL,
      WAIT_CTRL,
      DONE,
      ERR
   } state_t;

   state_t                  state_q, state_d;
   logic [RW-1:0]           retry_q, retry_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    pause_en_q, pause_en_d;
   logic [15:0]             pause_thr_q, pause_thr_d;
   logic [15:0]             drop_thr_q, drop_thr_d;
   logic                    error_q, error_d;
   logic [1:0]              code_q, code_d;
   logic                    done_q, done_d;
   logic                    read_q, read_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

   logic [DATA_WIDTH-1:0]   thr_expect;
   logic                    rsp_match;

   assign thr_expect = DATA_WIDTH'({drop_thr_q, pause_thr_q});

   // Control register compares bit 0 only; the remaining bits are don't-care on readback.
   assign rsp_match = (state_q == WAIT_THR) ? (avmm_readdata == thr_expect)
                                            : (avmm_readdata[0] == pause_en_q);

   always_comb begin
      state_d     = state_q;
      retry_d     = retry_q;
      tmo_d       = '0;
      pause_en_d  = pause_en_q;
      pause_thr_d = pause_thr_q;
      drop_thr_d  = drop_thr_q;
      error_d     = error_q;
      code_d      = code_q;

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d     = WR_THR;
               pause_en_d  = cfg_rx_pause_en;
               pause_thr_d = cfg_rx_pause_threshold;
               drop_thr_d  = cfg_drop_threshold;
               error_d     = 1'b0;
               code_d      = 2'b00;
               retry_d     = '0;
            end
         end
         WR_THR:  state_d = WR_CTRL;
         WR_CTRL: state_d = RD_THR;
         RD_THR:  state_d = WAIT_THR;
         RD_CTRL: state_d = WAIT_CTRL;
         WAIT_THR, WAIT_CTRL: begin
            tmo_d = tmo_q + TW'(1);
            if (avmm_readdata_valid) begin
               if (rsp_match) begin
                  state_d = (state_q == WAIT_THR) ? RD_CTRL : DONE;
               end else if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + RW'(1);
                  state_d = WR_THR;
               end else begin
                  state_d = ERR;
                  error_d = 1'b1;
                  code_d  = ERR_MISMATCH;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = ERR;
               error_d = 1'b1;
               code_d  = ERR_TIMEOUT;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Bus outputs are decoded from the next state so each command is registered
      // and lands in the same cycle the FSM enters its command state.
      write_d = (state_d == WR_THR) || (state_d == WR_CTRL);
      read_d  = (state_d == RD_THR) || (state_d == RD_CTRL);

      case (state_d)
         WR_THR, RD_THR:   addr_d = THR_ADDR;
         WR_CTRL, RD_CTRL: addr_d = CTRL_ADDR;
         default:          addr_d = '0;
      endcase

      case (state_d)
         WR_THR:  wdata_d = DATA_WIDTH'({drop_thr_d, pause_thr_d});
         WR_CTRL: wdata_d = DATA_WIDTH'(pause_en_d);
         default: wdata_d = '0;
      endcase

      done_d = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         retry_q     <= '0;
         tmo_q       <= '0;
         pause_en_q  <= 1'b0;
         pause_thr_q <= '0;
         drop_thr_q  <= '0;
         error_q     <= 1'b0;
         code_q      <= 2'b00;
         done_q      <= 1'b0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         retry_q     <= retry_d;
         tmo_q       <= tmo_d;
         pause_en_q  <= pause_en_d;
         pause_thr_q <= pause_thr_d;
         drop_thr_q  <= drop_thr_d;
         error_q     <= error_d;
         code_q      <= code_d;
         done_q      <= done_d;
         read_q      <= read_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign cfg_busy        = (state_q != IDLE);
   assign cfg_done        = done_q;
   assign cfg_error       = error_q;
   assign cfg_err_code    = code_q;
   assign avmm_address    = addr_q;
   assign avmm_read       = read_q;
   assign avmm_write      = write_q;
   assign avmm_writedata  = wdata_q;
   assign avmm_byteenable = '1;

endmodule

// File: tb/tb_wadj_csr_cfg_master.sv
// Bench for wadj_csr_cfg_master: CSR responder model with fixed read latency,
// expected-write scoreboard and a table of programming scenarios.
`timescale 1ns/1ps
module tb_wadj_csr_cfg_master;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic        cfg_rx_pause_en = 1'b0;
   logic [15:0] cfg_rx_pause_threshold = '0;
   logic [15:0] cfg_drop_threshold = '0;
   logic        cfg_busy, cfg_done, cfg_error;
   logic [1:0]  cfg_err_code;
   logic [7:0]  avmm_address;
   logic        avmm_read, avmm_write;
   logic [31:0] avmm_writedata;
   logic [3:0]  avmm_byteenable;
   logic [31:0] avmm_readdata = '0;
   logic        avmm_readdata_valid = 1'b0;

   always #5 clk = ~clk;

   wadj_csr_cfg_master dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .cfg_start              (cfg_start),
      .cfg_rx_pause_en        (cfg_rx_pause_en),
      .cfg_rx_pause_threshold (cfg_rx_pause_threshold),
      .cfg_drop_threshold     (cfg_drop_threshold),
      .cfg_busy               (cfg_busy),
      .cfg_done               (cfg_done),
      .cfg_error              (cfg_error),
      .cfg_err_code           (cfg_err_code),
      .avmm_address           (avmm_address),
      .avmm_read              (avmm_read),
      .avmm_write             (avmm_write),
      .avmm_writedata         (avmm_writedata),
      .avmm_byteenable        (avmm_byteenable),
      .avmm_readdata          (avmm_readdata),
      .avmm_readdata_valid    (avmm_readdata_valid)
   );

   int nchk = 0;
   int nfail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_wr_q[$];
   int  wr_cnt = 0;

   // Responder model state
   logic [31:0] reg_ctrl = '0;
   logic [31:0] reg_thr = '0;
   int          corrupt_left = 0;
   bit          ctrl_ovr = 1'b0;
   bit          drop_ctrl = 1'b0;
   bit          pend = 1'b0;
   int          pend_due = 0;
   logic [31:0] pend_data = '0;
   wr_t         rsp_e;
   logic [31:0] rsp_d;

   always @(negedge clk) begin : responder
      avmm_readdata_valid = 1'b0;
      if (pend && cyc == pend_due) begin
         avmm_readdata_valid = 1'b1;
         avmm_readdata       = pend_data;
         pend                = 1'b0;
      end
      if (avmm_read || avmm_write)
         chk("rd_wr_overlap", 32'(avmm_read & avmm_write), 32'h0);
      if (avmm_write) begin
         wr_cnt++;
         if (avmm_address == 8'h4) reg_thr = avmm_writedata;
         else if (avmm_address == 8'h0) reg_ctrl = avmm_writedata;
         if (exp_wr_q.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required none",
                     avmm_address, avmm_writedata);
         end else begin
            rsp_e = exp_wr_q.pop_front();
            chk("wr_addr", 32'(avmm_address), 32'(rsp_e.addr));
            chk("wr_data", avmm_writedata, rsp_e.data);
         end
      end
      if (avmm_read) begin
         rsp_d = (avmm_address == 8'h4) ? reg_thr : reg_ctrl;
         if (avmm_address == 8'h4 && corrupt_left > 0) begin
            rsp_d = rsp_d ^ 32'h1;
            corrupt_left--;
         end
         if (avmm_address == 8'h0 && ctrl_ovr) rsp_d = 32'hFFFF_FFF1;
         if (!(avmm_address == 8'h0 && drop_ctrl)) begin
            pend      = 1'b1;
            pend_due  = cyc + L;
            pend_data = rsp_d;
         end
      end
   end

   task automatic push_seq(input logic pe, input logic [15:0] pthr, input logic [15:0] drop, input int nseq);
      wr_t w;
      for (int s = 0; s < nseq; s++) begin
         w.addr = 8'h4; w.data = {drop, pthr}; exp_wr_q.push_back(w);
         w.addr = 8'h0; w.data = {31'b0, pe};  exp_wr_q.push_back(w);
      end
   endtask

   task automatic run_case(input string nm, input logic pe, input logic [15:0] pthr,
                           input logic [15:0] drop, input int nseq, input bit exp_done,
                           input logic [1:0] exp_code, input int exp_cyc);
      int t0;
      int rel;
      bit seen_done;
      bit seen_err;
      wr_cnt = 0;
      seen_done = 1'b0;
      seen_err = 1'b0;
      push_seq(pe, pthr, drop, nseq);
      @(posedge clk); #1;
      cfg_start = 1'b1;
      cfg_rx_pause_en = pe;
      cfg_rx_pause_threshold = pthr;
      cfg_drop_threshold = drop;
      t0 = cyc;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      rel = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cfg_done || cfg_error) begin
            rel = cyc - t0;
            seen_done = cfg_done;
            seen_err = cfg_error;
            break;
         end
      end
      if (rel < 0) begin
         nchk++;
         nfail++;
         $display("FAIL %s_completion: actual=none required=cycle %0d", nm, exp_cyc);
      end else begin
         chk({nm, "_cycle"}, 32'(rel), 32'(exp_cyc));
         chk({nm, "_done"}, 32'(seen_done), 32'(exp_done));
         chk({nm, "_error"}, 32'(seen_err), 32'(!exp_done));
         chk({nm, "_code"}, 32'(cfg_err_code), 32'(exp_code));
         @(negedge clk);
         chk({nm, "_busy_after"}, 32'(cfg_busy), 32'h0);
         chk({nm, "_done_pulse"}, 32'(cfg_done), 32'h0);
         chk({nm, "_err_sticky"}, 32'(cfg_error), 32'(!exp_done));
      end
      chk({nm, "_writes"}, 32'(wr_cnt), 32'(2 * nseq));
      chk({nm, "_wr_left"}, 32'(exp_wr_q.size()), 32'h0);
      exp_wr_q.delete();
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_busy"}, 32'(cfg_busy), 32'h0);
      chk({nm, "_done"}, 32'(cfg_done), 32'h0);
      chk({nm, "_error"}, 32'(cfg_error), 32'h0);
      chk({nm, "_code"}, 32'(cfg_err_code), 32'h0);
      chk({nm, "_read"}, 32'(avmm_read), 32'h0);
      chk({nm, "_write"}, 32'(avmm_write), 32'h0);
      chk({nm, "_addr"}, 32'(avmm_address), 32'h0);
      chk({nm, "_wdata"}, avmm_writedata, 32'h0);
      chk({nm, "_be"}, 32'(avmm_byteenable), 32'hF);
   endtask

   typedef struct {
      logic        pe;
      logic [15:0] pthr;
      logic [15:0] drop;
      int          corrupt;
      bit          ovr;
      bit          dropc;
      int          nseq;
      bit          exp_done;
      logic [1:0]  code;
      int          cyc;
   } vec_t;
   vec_t tbl[7];

   initial begin : watchdog
      #200us;
      $display("FAIL watchdog: actual=no finish required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      tbl[0] = '{1'b1, 16'h0100, 16'h0200, 0, 1'b0, 1'b0, 1, 1'b1, 2'b00, 10};
      tbl[1] = '{1'b1, 16'h0100, 16'h0200, 1, 1'b0, 1'b0, 2, 1'b1, 2'b00, 15};
      tbl[2] = '{1'b1, 16'h0100, 16'h0200, 3, 1'b0, 1'b0, 3, 1'b0, 2'b10, 16};
      tbl[3] = '{1'b1, 16'h0100, 16'h0200, 0, 1'b1, 1'b0, 1, 1'b1, 2'b00, 10};
      tbl[4] = '{1'b0, 16'hFFFF, 16'h0000, 0, 1'b0, 1'b0, 1, 1'b1, 2'b00, 10};
      tbl[5] = '{1'b0, 16'h0100, 16'h0200, 0, 1'b1, 1'b0, 3, 1'b0, 2'b10, 25};
      tbl[6] = '{1'b1, 16'h0100, 16'h0200, 0, 1'b0, 1'b1, 1, 1'b0, 2'b01, 71};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("por");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 7; i++) begin
         corrupt_left = tbl[i].corrupt;
         ctrl_ovr     = tbl[i].ovr;
         drop_ctrl    = tbl[i].dropc;
         run_case($sformatf("vec%0d", i), tbl[i].pe, tbl[i].pthr, tbl[i].drop, tbl[i].nseq,
                  tbl[i].exp_done, tbl[i].code, tbl[i].cyc);
      end
      corrupt_left = 0;
      ctrl_ovr = 1'b0;
      drop_ctrl = 1'b0;

      // Start while busy, then abort with reset while waiting for the threshold readback.
      wr_cnt = 0;
      push_seq(1'b1, 16'h1111, 16'h2222, 1);
      @(posedge clk); #1;
      cfg_start = 1'b1;
      cfg_rx_pause_en = 1'b1;
      cfg_rx_pause_threshold = 16'h1111;
      cfg_drop_threshold = 16'h2222;
      @(posedge clk); #1;
      cfg_rx_pause_en = 1'b0;
      cfg_rx_pause_threshold = 16'h3333;
      cfg_drop_threshold = 16'h4444;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_busy_before", 32'(cfg_busy), 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("late_rsp_busy", 32'(cfg_busy), 32'h0);
         chk("late_rsp_read", 32'(avmm_read), 32'h0);
      end
      chk("abort_writes", 32'(wr_cnt), 32'h2);
      chk("abort_wr_left", 32'(exp_wr_q.size()), 32'h0);
      exp_wr_q.delete();

      run_case("fresh", 1'b1, 16'h0100, 16'h0200, 1, 1'b1, 2'b00, 10);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/wadj_csr_cfg_master.md
# wadj_csr_cfg_master

Avalon-MM initiator that programs and verifies the ingress width-adjuster CSR block (rx pause enable, rx pause threshold, drop threshold) from a single start request. It sits between the bridge's local configuration source (bring-up sequencer or software shadow registers) and the width-adjuster CSR responder, and is the initiator end of that AVMM link. Each sequence writes the threshold register, then the control register, then reads both back and compares. On mismatch it retries a bounded number of times. On a missing read response it times out.

## Interface
- ADDR_WIDTH, 8, AVMM address width.
- DATA_WIDTH, 32, AVMM data width; fixed at 32 for this register map.
- BASE_ADDR, 'h0, base address of the width-adjuster CSR window.
- MAX_RETRY, 2, number of full re-sequences allowed after a readback mismatch.
- TIMEOUT_CYCLES, 64, maximum wait for avmm_readdata_valid after a read command.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle request to run a sequence.
- cfg_rx_pause_en  in  1  value to program into the control register, bit 0.
- cfg_rx_pause_threshold  in  16  value for threshold register bits [15:0].
- cfg_drop_threshold  in  16  value for threshold register bits [31:16].
- cfg_busy  out  1  sequence in progress.
- cfg_done  out  1  one-cycle pulse: programming verified.
- cfg_error  out  1  sticky failure flag.
- cfg_err_code  out  2  01 = read timeout, 10 = mismatch after retries exhausted.
- avmm_address  out  ADDR_WIDTH  command address.
- avmm_read  out  1  read command.
- avmm_write  out  1  write command.
- avmm_writedata  out  DATA_WIDTH  write data.
- avmm_byteenable  out  DATA_WIDTH/8  always all-ones.
- avmm_readdata  in  DATA_WIDTH  read response data.
- avmm_readdata_valid  in  1  read response strobe.

## Operation
- Register map (byte offsets from BASE_ADDR):
  - 0x0 = control register; bit 0 = rx_pause_en; other bits write 0 and are ignored on compare.
  - 0x4 = threshold register; [15:0] = rx pause threshold, [31:16] = drop threshold.
- Responder protocol: no waitrequest, so every command is accepted in the cycle it is asserted. Each read returns exactly one readdata_valid, at least 1 cycle after the command.
- Only one command is outstanding at a time.
- Reset values of all outputs are 0. The exception is avmm_byteenable, which is all-ones.
- FSM states: IDLE, WR_THR, WR_CTRL, RD_THR, WAIT_THR, RD_CTRL, WAIT_CTRL, DONE, ERR.
- IDLE:
  - On cfg_start, latch all three cfg inputs and clear cfg_error/cfg_err_code.
  - Clear the retry counter (width $clog2(MAX_RETRY+1)) and go to WR_THR.
- WR_THR: one-cycle write of {drop, pause_threshold} to BASE_ADDR+4, then go to WR_CTRL.
- WR_CTRL: one-cycle write of {31'b0, pause_en} to BASE_ADDR+0. Thresholds are always written before enable. Go to RD_THR.
- RD_THR: one-cycle read of BASE_ADDR+4, then go to WAIT_THR.
- WAIT_THR:
  - On readdata_valid, compare all 32 bits to the latched value.
  - Match: go to RD_CTRL.
  - Mismatch with retry counter < MAX_RETRY: increment the counter and go to WR_THR.
  - Mismatch with retries exhausted: go to ERR with code 10.
- RD_CTRL / WAIT_CTRL: same as RD_THR / WAIT_THR, reading BASE_ADDR+0 and comparing bit 0 only. A match goes to DONE.
- Timeout:
  - The timeout counter clears on entry to any WAIT state.
  - If it reaches TIMEOUT_CYCLES without readdata_valid, go to ERR with code 01. No retry is attempted on a timeout.
- DONE: cfg_done=1 for one cycle, then go to IDLE.
- ERR: set cfg_error and cfg_err_code (held until the next cfg_start), then go to IDLE.
- cfg_busy=1 in every state except IDLE.
- cfg_start while busy is ignored; the latched values are unchanged.
- readdata_valid outside a WAIT state is ignored.
- Asserting rst_n low mid-sequence aborts immediately:
  - outputs return to reset values;
  - any in-flight read response that arrives after reset is ignored.

## Timing
- cfg_start sampled high in cycle 0 → avmm_write with address BASE_ADDR+4 in cycle 1.
- Write to BASE_ADDR+0 in cycle 2. Read of BASE_ADDR+4 in cycle 3.
- avmm_read and avmm_write are registered outputs, each high for exactly 1 cycle per command, and never high together.
- A response in cycle N causes the next command (or DONE) in cycle N+1.
- For a responder with readdata_valid latency L, a clean sequence gives cfg_done in cycle 2L+6 after start, i.e. 10 for L=2.
- A timeout fires in cycle entry+TIMEOUT_CYCLES of the WAIT state.
- A new cfg_start is accepted in the cycle after DONE or ERR.

## Test plan
- Clean program: start with pause_en=1, pause_thr=0x0100, drop_thr=0x0200; model responder with L=2.
  - Writes: 0x02000100 to 0x4, then 0x1 to 0x0.
  - Reads back match; cfg_done in cycle 10; cfg_error=0.
- Single mismatch: responder corrupts the first threshold readback to 0x02000101.
  - One retry of the full write/read sequence.
  - cfg_done asserted; total of 4 writes observed.
- Persistent mismatch with MAX_RETRY=2: 3 full sequences, then cfg_error=1, cfg_err_code=10, no cfg_done.
- Timeout: responder drops the control-register read response.
  - cfg_err_code=01 exactly 64 cycles after entering WAIT_CTRL; cfg_busy low the next cycle.
- Start while busy, then rst_n pulsed low mid-WAIT_THR:
  - the second start does not change the written values;
  - after reset all outputs are 0 and the late readdata_valid is ignored;
  - a fresh start completes normally.
- Control compare masking: responder returns 0xFFFF_FFF1 for the control read with pause_en=1 → treated as a match, cfg_done asserted.
